// File: rtl/aes_sbox_pkg.sv
// aes_pkg: shared types and constants for the AES byte-substitution block.
// Contents:
//   aes_byte_t          8-bit data byte
//   AES_SBOX            forward S-box, 256 entries, indexed by input byte
//   AES_INV_SBOX        inverse S-box, present only when AES_SBOX_INV_EN is defined
//   AES_SBOX_AFFINE_C   affine-transform constant of the forward S-box
// Optional feature macro: AES_SBOX_INV_EN
package aes_pkg;

  typedef logic [7:0] aes_byte_t;

  localparam aes_byte_t AES_SBOX_AFFINE_C = 8'h63;

  // Row r, column c holds SBOX[16*r + c].
  localparam aes_byte_t AES_SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

`ifdef AES_SBOX_INV_EN
  // Kept behind the macro so the forward-only build carries no inverse table.
  localparam aes_byte_t AES_INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };
`endif

endpackage

// File: rtl/aes_sbox_if.sv
// aes_sbox_if: byte-substitution request/result bundle.
// Signals:
//   in_valid  request carries a byte this cycle
//   b         input byte
//   inv       1 = inverse S-box (only when AES_SBOX_INV_EN is defined)
//   out_valid result register holds a value from a valid request
//   b_        registered substituted byte
// Modports: master drives requests, slave is the S-box.
interface aes_sbox_if;
  import aes_pkg::*;

  logic      in_valid;
  aes_byte_t b;
`ifdef AES_SBOX_INV_EN
  logic      inv;
`endif
  logic      out_valid;
  aes_byte_t b_;

`ifdef AES_SBOX_INV_EN
  modport master (output in_valid, output b, output inv, input out_valid, input b_);
  modport slave  (input in_valid, input b, input inv, output out_valid, output b_);
`else
  modport master (output in_valid, output b, input out_valid, input b_);
  modport slave  (input in_valid, input b, output out_valid, output b_);
`endif

endinterface

// File: rtl/aes_sbox.sv
// aes_sbox: registered AES SubBytes substitution, one byte per cycle,
// one-cycle latency, no backpressure.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  aes_sbox_if.slave (in_valid, b, [inv], out_valid, b_)
// Parameter RESET_VAL: value of b_ after reset.
// Optional feature macro: AES_SBOX_INV_EN adds the inv select for the inverse S-box.
module aes_sbox
  import aes_pkg::*;
#(
  parameter aes_byte_t RESET_VAL = 8'h00
) (
  input  logic        clk,
  input  logic        rst,
  aes_sbox_if.slave   bus
);

  aes_byte_t sub_d;
  aes_byte_t b_q;
  logic      valid_q;

  // Pure table lookup straight into the register D input.
  always_comb begin
`ifdef AES_SBOX_INV_EN
    sub_d = bus.inv ? AES_INV_SBOX[bus.b] : AES_SBOX[bus.b];
`else
    sub_d = AES_SBOX[bus.b];
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      b_q     <= RESET_VAL;
    end else begin
      valid_q <= bus.in_valid;
      if (bus.in_valid) begin
        b_q <= sub_d;
      end
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.b_        = b_q;

endmodule

// File: tb/tb_aes_sbox.sv
// tb_aes_sbox: directed self-checking bench for aes_sbox.
// Reference S-box is computed from GF(2^8) arithmetic, independent of the RTL table.
module tb_aes_sbox;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_checks = 0;
  int   n_errors = 0;

  aes_sbox_if bus_if ();

  aes_sbox #(.RESET_VAL(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       vld;
    logic [7:0] b;
    logic       ev;
    logic [7:0] eb;
  } vec_t;

  function automatic logic [7:0] xtime(logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] m);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (m[0]) p = p ^ a;
      a = xtime(a);
      m = m >> 1;
    end
    return p;
  endfunction

  // a^254 is the multiplicative inverse; 0 maps to 0 naturally.
  function automatic logic [7:0] ginv(logic [7:0] a);
    logic [7:0] r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, a);
    return r;
  endfunction

  function automatic logic [7:0] rotl(logic [7:0] x, int k);
    return (x << k) | (x >> (8 - k));
  endfunction

  function automatic logic [7:0] sbox_ref(logic [7:0] x);
    logic [7:0] i = ginv(x);
    return i ^ rotl(i, 1) ^ rotl(i, 2) ^ rotl(i, 3) ^ rotl(i, 4) ^ 8'h63;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] ref_tab [256];
  logic       seen [256];
  vec_t       vecs [9];
  int         distinct;

  initial begin
    bus_if.in_valid = 1'b0;
    bus_if.b        = 8'h00;
`ifdef AES_SBOX_INV_EN
    bus_if.inv      = 1'b0;
`endif
    for (int i = 0; i < 256; i++) ref_tab[i] = sbox_ref(8'(i));

    // Reset with a valid request pending, then spot values.
    vecs[0] = '{1'b1, 1'b1, 8'h53, 1'b0, 8'h00};
    vecs[1] = '{1'b1, 1'b1, 8'h53, 1'b0, 8'h00};
    vecs[2] = '{1'b0, 1'b1, 8'h00, 1'b1, 8'h63};
    vecs[3] = '{1'b0, 1'b1, 8'h01, 1'b1, 8'h7c};
    vecs[4] = '{1'b0, 1'b1, 8'h10, 1'b1, 8'hca};
    vecs[5] = '{1'b0, 1'b1, 8'h53, 1'b1, 8'hed};
    vecs[6] = '{1'b0, 1'b1, 8'h80, 1'b1, 8'hcd};
    vecs[7] = '{1'b0, 1'b1, 8'hff, 1'b1, 8'h16};
    vecs[8] = '{1'b0, 1'b1, 8'ha5, 1'b1, 8'h06};

    for (int i = 0; i < 9; i++) begin
      rst             = vecs[i].rst;
      bus_if.in_valid = vecs[i].vld;
      bus_if.b        = vecs[i].b;
      step();
      check($sformatf("vec%0d_valid", i), {7'd0, bus_if.out_valid}, {7'd0, vecs[i].ev});
      check($sformatf("vec%0d_b_", i), bus_if.b_, vecs[i].eb);
    end

    // Hold: A5 -> 06 was just produced; idle cycles must keep it.
    for (int i = 0; i < 3; i++) begin
      bus_if.in_valid = 1'b0;
      bus_if.b        = (i % 2 == 0) ? 8'h00 : 8'hff;
      step();
      check($sformatf("hold%0d_valid", i), {7'd0, bus_if.out_valid}, 8'h00);
      check($sformatf("hold%0d_b_", i), bus_if.b_, 8'h06);
    end

    // Exhaustive back-to-back sweep.
    for (int i = 0; i < 256; i++) seen[i] = 1'b0;
    for (int i = 0; i < 256; i++) begin
      bus_if.in_valid = 1'b1;
      bus_if.b        = 8'(i);
      step();
      check($sformatf("sweep%0d_valid", i), {7'd0, bus_if.out_valid}, 8'h01);
      check($sformatf("sweep%0d_b_", i), bus_if.b_, ref_tab[i]);
      seen[bus_if.b_] = 1'b1;
    end
    distinct = 0;
    for (int i = 0; i < 256; i++) if (seen[i]) distinct++;
    n_checks++;
    if (distinct != 256) begin
      n_errors++;
      $display("FAIL sweep_distinct: got %0d expected 256", distinct);
    end

    // Reset mid-stream: 53 presented, rst on the next edge discards ED.
    bus_if.in_valid = 1'b1;
    bus_if.b        = 8'h53;
    step();
    rst             = 1'b1;
    bus_if.in_valid = 1'b1;
    bus_if.b        = 8'h01;
    step();
    check("midrst_valid", {7'd0, bus_if.out_valid}, 8'h00);
    check("midrst_b_", bus_if.b_, 8'h00);
    rst             = 1'b0;
    bus_if.in_valid = 1'b1;
    bus_if.b        = 8'h53;
    step();
    check("post_rst_b_", bus_if.b_, 8'hed);

`ifdef AES_SBOX_INV_EN
    begin
      logic [7:0] inv_in  [3] = '{8'h63, 8'hed, 8'h00};
      logic [7:0] inv_exp [3] = '{8'h00, 8'h53, 8'h52};
      for (int i = 0; i < 3; i++) begin
        bus_if.inv      = 1'b1;
        bus_if.in_valid = 1'b1;
        bus_if.b        = inv_in[i];
        step();
        check($sformatf("inv%0d_b_", i), bus_if.b_, inv_exp[i]);
        check($sformatf("inv%0d_valid", i), {7'd0, bus_if.out_valid}, 8'h01);
      end
      for (int i = 0; i < 256; i++) begin
        bus_if.inv = 1'b0;
        bus_if.b   = 8'(i);
        step();
        check($sformatf("rt_fwd%0d", i), bus_if.b_, ref_tab[i]);
        bus_if.inv = 1'b1;
        bus_if.b   = bus_if.b_;
        step();
        check($sformatf("rt_inv%0d", i), bus_if.b_, 8'(i));
      end
      bus_if.inv = 1'b0;
    end
`endif

    bus_if.in_valid = 1'b0;
    step();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
